karat_prod_serializer: RTL and testbench

//  Downstream of karat_mult_recursion: captures the wide product oO when o_finish rises.

---
 rtl/karat_prod_serializer.sv | 75 +++++++
 tb/tb_karat_prod_serializer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/karat_prod_serializer.sv
// karat_prod_serializer: ping-pong buffers a wide product on the rising edge of i_finish and streams it out as wW-bit words, LSW first.
// Optional o_par even-parity output is enabled by defining KARAT_SER_PARITY_EN.
module karat_prod_serializer #(
  parameter int wO = 2048,
  parameter int wW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_finish,
  input  logic [wO-1:0] iP,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [wW-1:0] o_data,
  output logic          o_last,
  output logic          o_busy,
  output logic          o_full,
  output logic          o_overflow
`ifdef KARAT_SER_PARITY_EN
  ,
  output logic          o_par
`endif
);
  localparam int nWORD = wO / wW;
  localparam int IW = $clog2(nWORD);
  localparam logic [IW-1:0] LAST = IW'(nWORD - 1);
  logic [nWORD-1:0][wW-1:0] buf0, buf1;
  logic fin_q, wr_ptr, rd_ptr;
  logic [1:0] cnt;
  logic [IW-1:0] idx;
  logic cap, xfer, done, acc;
  assign cap = i_finish & ~fin_q;
  assign xfer = o_valid & i_ready;
  assign done = xfer & (idx == LAST);
  // a full pipe still accepts when the last word of the older product leaves this cycle
  assign acc = cap & ((cnt != 2'd2) | done);
  assign o_valid = cnt != 2'd0;
  assign o_busy = o_valid;
  assign o_full = cnt == 2'd2;
  assign o_data = o_valid ? (rd_ptr ? buf1[idx] : buf0[idx]) : '0;
  assign o_last = o_valid & (idx == LAST);
`ifdef KARAT_SER_PARITY_EN
  assign o_par = ^o_data;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0 <= '0;
      buf1 <= '0;
      fin_q <= 1'b0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt <= 2'd0;
      idx <= '0;
      o_overflow <= 1'b0;
    end else begin
      fin_q <= i_finish;
      if (i_clr) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        cnt <= 2'd0;
        idx <= '0;
        o_overflow <= 1'b0;
      end else begin
        if (xfer) idx <= done ? '0 : idx + 1'b1;
        if (done) rd_ptr <= ~rd_ptr;
        if (acc) begin
          if (wr_ptr) buf1 <= iP;
          else buf0 <= iP;
          wr_ptr <= ~wr_ptr;
        end else if (cap) o_overflow <= 1'b1;
        cnt <= cnt + {1'b0, acc} - {1'b0, done};
      end
    end
  end
endmodule

// File: tb/tb_karat_prod_serializer.sv
// tb_karat_prod_serializer: directed and random stimulus against a queue-of-products reference model.
module tb_karat_prod_serializer;
  localparam int wO = 256;
  localparam int wW = 64;
  logic clk = 1'b0;
  logic rst_n, i_clr, i_finish, i_ready;
  logic [wO-1:0] iP;
  logic o_valid, o_last, o_busy, o_full, o_overflow;
  logic [wW-1:0] o_data;
`ifdef KARAT_SER_PARITY_EN
  logic o_par;
`endif
  karat_prod_serializer #(.wO(wO), .wW(wW)) dut (
    .clk(clk), .rst_n(rst_n), .i_clr(i_clr), .i_finish(i_finish), .iP(iP),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last),
    .o_busy(o_busy), .o_full(o_full), .o_overflow(o_overflow)
`ifdef KARAT_SER_PARITY_EN
    , .o_par(o_par)
`endif
  );
  always #5 clk = ~clk;
  logic [wO-1:0] mq[$];
  int pos;
  bit movf, mprev;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    logic [wO-1:0] h;
    logic [63:0] w;
    bit v;
    v = mq.size() != 0;
    h = v ? mq[0] : '0;
    w = v ? h[pos*64 +: 64] : 64'd0;
    chk("valid", o_valid, v);
    chk("data", o_data, w);
    chk("last", o_last, v && pos == 3);
    chk("busy", o_busy, v);
    chk("full", o_full, mq.size() == 2);
    chk("overflow", o_overflow, movf);
`ifdef KARAT_SER_PARITY_EN
    chk("par", o_par, ^w);
`endif
  endtask
  task automatic cyc(input bit fin, input bit rdy, input bit clr, input logic [wO-1:0] p);
    bit xf, cp;
    i_finish = fin;
    i_ready = rdy;
    i_clr = clr;
    iP = p;
    xf = mq.size() != 0 && rdy;
    cp = fin && !mprev;
    if (clr) begin
      mq.delete();
      pos = 0;
      movf = 0;
    end else begin
      if (xf) begin
        if (pos == 3) begin
          void'(mq.pop_front());
          pos = 0;
        end else pos++;
      end
      if (cp) begin
        if (mq.size() < 2) mq.push_back(p);
        else movf = 1;
      end
    end
    mprev = fin;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask
  function automatic logic [wO-1:0] mk(input logic [63:0] a, b, c, d);
    return {d, c, b, a};
  endfunction
  function automatic logic [wO-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction
  logic [wO-1:0] p1, pa, pb, pc;
  initial begin
    rst_n = 1'b0;
    i_clr = 1'b0;
    i_finish = 1'b0;
    i_ready = 1'b0;
    iP = '0;
    pos = 0;
    movf = 0;
    mprev = 0;
    p1 = mk(64'd1, 64'd2, 64'd3, 64'd4);
    pa = rnd();
    pb = rnd();
    pc = rnd();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    repeat (2) cyc(0, 1, 0, '0);
    // single product, consumer always ready
    cyc(1, 1, 0, p1);
    chk("t2_first_word", o_data, 64'd1);
    repeat (5) cyc(0, 1, 0, p1);
    // stalls on every other cycle
    cyc(1, 0, 0, p1);
    for (int i = 0; i < 9; i++) cyc(0, i % 2 == 0, 0, p1);
    // three captures while stalled: the third overflows
    cyc(0, 0, 1, '0);
    cyc(1, 0, 0, pa);
    cyc(0, 0, 0, pa);
    cyc(1, 0, 0, pb);
    chk("t4_full", o_full, 1'b1);
    cyc(0, 0, 0, pb);
    cyc(1, 0, 0, pc);
    chk("t4_overflow", o_overflow, 1'b1);
    repeat (10) cyc(0, 1, 0, '0);
    // capture coinciding with last-word transfer while full
    cyc(0, 0, 1, '0);
    cyc(1, 0, 0, pa);
    cyc(0, 0, 0, pa);
    cyc(1, 0, 0, pb);
    cyc(0, 0, 0, pb);
    repeat (3) cyc(0, 1, 0, '0);
    chk("t5_last_pending", o_last, 1'b1);
    cyc(1, 1, 0, pc);
    chk("t5_no_overflow", o_overflow, 1'b0);
    chk("t5_still_full", o_full, 1'b1);
    repeat (9) cyc(0, 1, 0, '0);
    // level-held finish yields one capture
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, p1);
    repeat (2) cyc(0, 1, 0, '0);
    // clear overrides a same-cycle capture mid-stream
    cyc(1, 1, 0, pa);
    cyc(0, 1, 0, pa);
    cyc(1, 1, 1, pb);
    chk("clr_empty", o_valid, 1'b0);
    repeat (2) cyc(0, 1, 0, '0);
`ifdef KARAT_SER_PARITY_EN
    cyc(1, 0, 0, mk(64'h3, 64'h7, 64'h0, 64'h1));
    chk("par_3", o_par, 1'b0);
    cyc(0, 1, 0, '0);
    chk("par_7", o_par, 1'b1);
    cyc(0, 0, 1, '0);
`endif
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0, rnd());
    // asynchronous reset in the middle of a product
    cyc(1, 1, 0, pa);
    cyc(0, 1, 0, pa);
    #2;
    rst_n = 1'b0;
    i_finish = 1'b0;
    #1;
    mq.delete();
    pos = 0;
    movf = 0;
    mprev = 0;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc(0, 1, 0, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
